// File: rtl/rib_arbiter_if.sv
// Request/grant bundle between the rib masters and the bus arbiter.
// The arbiter connects through the slave modport, the requesters through the master modport.
interface rib_arbiter_if #(
    parameter int unsigned NUM_MASTERS = 4
);
    localparam int unsigned GW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

    logic [NUM_MASTERS-1:0] req_i;
    logic [NUM_MASTERS-1:0] lock_i;
    logic [NUM_MASTERS-1:0] gnt_o;
    logic [GW-1:0]          gnt_idx_o;
    logic                   gnt_valid_o;
    logic                   hold_flag_o;
    logic                   timeout_o;

    modport master (
        output req_i, lock_i,
        input  gnt_o, gnt_idx_o, gnt_valid_o, hold_flag_o, timeout_o
    );

    modport slave (
        input  req_i, lock_i,
        output gnt_o, gnt_idx_o, gnt_valid_o, hold_flag_o, timeout_o
    );
endinterface

// File: rtl/rib_arbiter.sv
// Round-robin rib bus arbiter with a fixed-priority master, locked ownership bounded by a
// watchdog, and a registered hold flag that stalls the core while a non-core master owns the bus.
module rib_arbiter #(
    parameter int unsigned           NUM_MASTERS = 4,
    parameter int unsigned           MAX_HOLD    = 16,
    parameter int unsigned           PRIO_MASTER = 3,
    parameter logic [NUM_MASTERS-1:0] CORE_MASK  = 4'b0011
) (
    input logic           clk,
    input logic           rst,
    rib_arbiter_if.slave  bus
);
    localparam int unsigned GW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

    typedef enum logic [1:0] {StIdle, StGrant, StLocked} state_e;

    state_e                 state_q, state_d;
    logic [NUM_MASTERS-1:0] gnt_q, gnt_d;
    logic [GW-1:0]          idx_q, idx_d;
    logic [GW-1:0]          rr_ptr_q, rr_ptr_d;
    logic [7:0]             hold_cnt_q, hold_cnt_d;
    logic                   hold_flag_q, hold_flag_d;
    logic                   timeout_q, timeout_d;

    logic                   owner_locked;
    logic                   timeout_hit;
    logic [NUM_MASTERS-1:0] mask;
    logic [NUM_MASTERS-1:0] cand;
    logic                   arb_found;
    logic [GW-1:0]          arb_win;
    logic [GW-1:0]          scan;
    logic                   arb_en;

    // gnt_q is one-hot, so masking with it selects the owner's request and lock bits.
    assign owner_locked = |(bus.req_i & gnt_q) & |(bus.lock_i & gnt_q);
    assign timeout_hit  = (state_q == StLocked) && owner_locked &&
                          (hold_cnt_q >= 8'(MAX_HOLD));
    assign mask         = timeout_hit ? gnt_q : '0;
    assign cand         = bus.req_i & ~mask;

    always_comb begin
        arb_found = 1'b0;
        arb_win   = '0;
        scan      = '0;
        if (cand[PRIO_MASTER]) begin
            arb_found = 1'b1;
            arb_win   = GW'(PRIO_MASTER);
        end else begin
            for (int i = 0; i < NUM_MASTERS; i++) begin
                scan = GW'((32'(rr_ptr_q) + 32'(i)) % NUM_MASTERS);
                if (!arb_found && cand[scan]) begin
                    arb_found = 1'b1;
                    arb_win   = scan;
                end
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        idx_d      = idx_q;
        rr_ptr_d   = rr_ptr_q;
        hold_cnt_d = hold_cnt_q;
        timeout_d  = 1'b0;
        arb_en     = 1'b0;

        unique case (state_q)
            StIdle: arb_en = 1'b1;
            StGrant: begin
                if (owner_locked) begin
                    state_d    = StLocked;
                    hold_cnt_d = 8'd2;
                end else begin
                    arb_en = 1'b1;
                end
            end
            StLocked: begin
                if (timeout_hit) begin
                    arb_en    = 1'b1;
                    timeout_d = 1'b1;
                end else if (owner_locked) begin
                    if (hold_cnt_q < 8'(MAX_HOLD)) hold_cnt_d = hold_cnt_q + 8'd1;
                end else begin
                    arb_en = 1'b1;
                end
            end
            default: arb_en = 1'b1;
        endcase

        if (arb_en) begin
            if (arb_found) begin
                state_d    = StGrant;
                gnt_d      = '0;
                gnt_d[arb_win] = 1'b1;
                idx_d      = arb_win;
                rr_ptr_d   = GW'((32'(arb_win) + 32'd1) % NUM_MASTERS);
                hold_cnt_d = 8'd1;
            end else begin
                state_d    = StIdle;
                gnt_d      = '0;
                idx_d      = '0;
                hold_cnt_d = 8'd0;
            end
        end

        hold_flag_d = |(gnt_d & ~CORE_MASK);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            gnt_q       <= '0;
            idx_q       <= '0;
            rr_ptr_q    <= '0;
            hold_cnt_q  <= '0;
            hold_flag_q <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            idx_q       <= idx_d;
            rr_ptr_q    <= rr_ptr_d;
            hold_cnt_q  <= hold_cnt_d;
            hold_flag_q <= hold_flag_d;
            timeout_q   <= timeout_d;
        end
    end

    assign bus.gnt_o       = gnt_q;
    assign bus.gnt_idx_o   = idx_q;
    assign bus.gnt_valid_o = |gnt_q;
    assign bus.hold_flag_o = hold_flag_q;
    assign bus.timeout_o   = timeout_q;
endmodule

// File: doc/rib_arbiter.md
Name: rib_arbiter

Overview:
- Round-robin bus arbiter with a fixed-priority override, sharing the rib interconnect between up to four masters:
  - m0: core data port
  - m1: core instruction fetch
  - m2: DMA/peripheral master
  - m3: uart_debug download master
- Registers a one-hot grant, supports multi-cycle locked ownership with a watchdog limit, and raises hold_flag_o to stall the core pipeline when a non-core master owns the bus.
- Sits between master request lines and the rib address/data muxes.

Parameters:
- NUM_MASTERS, 4, number of requesters; index width GW = clog2(NUM_MASTERS).
- MAX_HOLD, 16, maximum consecutive grant cycles for one locked owner; legal range 2..255.
- PRIO_MASTER, 3, master index that wins any arbitration in which it requests.
- CORE_MASK, 4'b0011, masters whose grant does NOT assert hold_flag_o.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- req_i  in  NUM_MASTERS  per-master bus request, level.
- lock_i  in  NUM_MASTERS  per-master lock request; meaningful only while that master is granted and requesting.
- gnt_o  out  NUM_MASTERS  registered one-hot grant; all-zero when idle.
- gnt_idx_o  out  GW  index of granted master; 0 when idle.
- gnt_valid_o  out  1  OR of gnt_o.
- hold_flag_o  out  1  gnt_valid_o & ~CORE_MASK[gnt_idx_o], registered together with the grant.
- timeout_o  out  1  one-cycle pulse when a locked owner is force-released.

Behaviour:
- Reset: all outputs 0, state IDLE, rr_ptr = 0, hold_cnt = 0, mask = 0. Reset mid-lock drops the grant immediately (asynchronous). No state survives reset.
- Latency: decision uses req_i/lock_i in cycle n; gnt_o changes at the edge ending cycle n, so the grant is visible in cycle n+1.
- States and transitions:
  - IDLE: no grant. Arbitrate each cycle. If no req_i, stay in IDLE.
  - GRANT: owner holds the bus for this cycle, unlocked.
    - If owner has req_i & lock_i: go to LOCKED, keep owner, hold_cnt = 2.
    - Otherwise: rearbitrate. Next state is GRANT, or IDLE if no requests.
  - LOCKED: owner keeps the grant while req_i[owner] & lock_i[owner], and hold_cnt increments.
    - Owner drops req_i or lock_i: rearbitrate normally next cycle.
    - Owner still locked when hold_cnt == MAX_HOLD:
      - next cycle: owner's gnt bit = 0; timeout_o = 1 for exactly that cycle;
      - owner is excluded (mask) from that one arbitration;
      - if no other requester, go to IDLE;
      - mask clears after one cycle.
- Arbitration (from IDLE/GRANT, or on leaving LOCKED):
  - Candidates = req_i & ~mask.
  - If candidate[PRIO_MASTER]: grant PRIO_MASTER.
  - Otherwise grant the first candidate scanning rr_ptr, rr_ptr+1, …, modulo NUM_MASTERS.
- Round-robin pointer:
  - On every new grant (including a re-grant to the same master), rr_ptr <= (granted idx + 1) mod NUM_MASTERS.
  - Unchanged during LOCKED continuation, and unchanged when no grant.
  - Pointer wrap: idx NUM_MASTERS-1 wraps to 0.
- hold_cnt:
  - Set to 1 on any new grant; 0 in IDLE.
  - Saturates at MAX_HOLD; never wraps.
- Unlocked owner with only itself requesting: re-granted every cycle as a new grant (hold_cnt = 1), so gnt_o stays high continuously.
- A master dropping req_i while granted loses the grant the following cycle. The grant is not revoked combinationally.
- lock_i from a non-granted master is ignored.
- Simultaneous timeout and PRIO_MASTER request: if the owner is PRIO_MASTER, the mask still excludes it for one cycle.
- hold_flag_o changes on the same edge as gnt_o; no glitches.
- Invariant: gnt_o is never more than one-hot.

Test Plan:
- Reset with req_i=4'b1111 -> gnt_o=0 during rst. First cycle after release, grant 4'b1000 (PRIO_MASTER), hold_flag_o=1.
- req_i=4'b0111 held for 6 cycles, lock_i=0 -> gnt_o sequence 0001, 0010, 0100, 0001, 0010, 0100 (rr_ptr 0 initial). hold_flag_o=1 only on 0100 cycles.
- m2 granted with req/lock held high, others requesting, MAX_HOLD=16 -> gnt_o=0100 for exactly 16 cycles. Then timeout_o=1 for one cycle, with the grant moving to m3 if it requests, else m0.
- m1 locked for 5 cycles then drops lock_i with req_i=4'b0011 -> grant moves to m0 next cycle; timeout_o stays 0; rr_ptr=1.
- Lone locked master m0 hits MAX_HOLD, no other requests -> one cycle gnt_o=0 with timeout_o=1, then gnt_o=0001 again with hold_cnt=1.
- Assert rst mid-LOCKED -> gnt_o, hold_flag_o and timeout_o go to 0 asynchronously. After release, arbitration restarts from rr_ptr=0.
